// File: rtl/instruction_memory_loadable.sv
// ---------------------------------------------------------------------------
// instruction_memory_loadable
//
// Program memory for the MIPS IF stage. At run time a byte stream (debug
// unit / UART side) is packed big-endian into words and written from word 0
// upward. Loading ends when the halt word has been stored, or when the last
// word of the array has been written. The block then serves registered,
// byte-addressed fetches. A fetch that is misaligned, outside the array, or
// past the last loaded word returns a NOP (all zeros) and raises o_addr_err.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   i_load_valid   load byte valid (accepted on any edge in LOAD)
//   i_load_byte    load byte; the first byte of a word lands in the MSBs
//   o_load_ready   high while the block accepts load bytes
//   i_load_clear   restart loading from word 0 (beats i_load_valid)
//   i_pc           fetch byte address
//   i_read_en      fetch enable; 0 stalls and holds the fetch outputs
//   o_instruction  fetched word, one cycle after the enabled edge
//   o_addr_err     fetch error flag, aligned with o_instruction
//   o_load_done    high in RUN
//   o_word_count   number of complete words written since the last restart
//
// state  | meaning
// -------+----------------------------------------------------------
// S_LOAD | packing bytes into words and writing them; fetches ignored
// S_RUN  | loading finished; serving fetches, load bytes ignored
// ---------------------------------------------------------------------------
module instruction_memory_loadable #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 6,
  parameter int                PC_W      = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'hFFFFFFFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic              o_load_ready,
  input  logic              i_load_clear,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_read_en,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_addr_err,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  // One extra bit so the limit itself is representable even when
  // DEPTH*4 == 2**PC_W.
  localparam logic [PC_W:0]     PC_LIMIT  = (PC_W + 1)'(DEPTH * 4);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [BC_W-1:0]     byte_cnt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]   asm_word;
  logic [DATA_W-1:0]   asm_next;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                byte_take;
  logic                word_done;
  logic                mem_we;
  logic [ADDR_W-1:0]   fetch_idx;
  logic                fetch_err;

  // Ready is forced low during reset so the byte source never sees a
  // handshake that the block is about to discard.
  assign o_load_ready = (state == S_LOAD) && !rst;
  assign o_load_done  = (state == S_RUN);

  assign byte_take = !rst && !i_load_clear && (state == S_LOAD) && i_load_valid;
  assign word_done = byte_take && (byte_cnt == LAST_BYTE);
  assign mem_we    = word_done;

  // Drop the incoming byte into its big-endian lane. On the last byte the
  // result is the complete word that goes to memory this edge.
  always_comb begin
    asm_next = asm_word;
    for (int k = 0; k < NB; k++) begin
      if (byte_cnt == BC_W'(k)) begin
        asm_next[DATA_W-1-8*k -: 8] = i_load_byte;
      end
    end
  end

  assign fetch_idx = i_pc[ADDR_W+1:2];
  assign fetch_err = (i_pc[1:0] != 2'b00)
                  || ({1'b0, i_pc} >= PC_LIMIT)
                  || ({1'b0, fetch_idx} >= o_word_count);

  // The array has no reset: contents survive reset and clear, and are
  // hidden by o_word_count until they are reloaded.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= asm_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOAD;
      byte_cnt      <= '0;
      wr_ptr        <= '0;
      asm_word      <= '0;
      o_word_count  <= '0;
      o_instruction <= '0;
      o_addr_err    <= 1'b0;
    end else if (i_load_clear) begin
      state         <= S_LOAD;
      byte_cnt      <= '0;
      wr_ptr        <= '0;
      asm_word      <= '0;
      o_word_count  <= '0;
      o_instruction <= '0;
      o_addr_err    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (byte_take) begin
            if (word_done) begin
              byte_cnt     <= '0;
              asm_word     <= '0;
              wr_ptr       <= wr_ptr + ADDR_W'(1);
              o_word_count <= o_word_count + (ADDR_W + 1)'(1);
              if ((asm_next == HALT_WORD) || (wr_ptr == LAST_WORD)) begin
                state <= S_RUN;
              end
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
              asm_word <= asm_next;
            end
          end
        end
        S_RUN: begin
          if (i_read_en) begin
            if (fetch_err) begin
              o_instruction <= '0;
              o_addr_err    <= 1'b1;
            end else begin
              o_instruction <= mem[fetch_idx];
              o_addr_err    <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
module tb_instruction_memory_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_load_valid;
  logic [7:0]  i_load_byte;
  logic        o_load_ready;
  logic        i_load_clear;
  logic [31:0] i_pc;
  logic        i_read_en;
  logic [31:0] o_instruction;
  logic        o_addr_err;
  logic        o_load_done;
  logic [6:0]  o_word_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_memory_loadable dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_valid (i_load_valid),
    .i_load_byte  (i_load_byte),
    .o_load_ready (o_load_ready),
    .i_load_clear (i_load_clear),
    .i_pc         (i_pc),
    .i_read_en    (i_read_en),
    .o_instruction(o_instruction),
    .o_addr_err   (o_addr_err),
    .o_load_done  (o_load_done),
    .o_word_count (o_word_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_clear();
    i_load_clear = 1'b1;
    tick();
    i_load_clear = 1'b0;
  endtask

  // One enabled fetch; checks data and error flag one edge later.
  task automatic fetch_check(input string name, input logic [31:0] pc,
                             input logic [31:0] exp_ins, input logic exp_err);
    i_pc      = pc;
    i_read_en = 1'b1;
    tick();
    i_read_en = 1'b0;
    checks++;
    if (o_instruction !== exp_ins) begin
      errors++;
      $display("FAIL %s instr: got %h want %h", name, o_instruction, exp_ins);
    end
    checks++;
    if (o_addr_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, o_addr_err, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_load_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", o_load_ready); end
    checks++;
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", o_load_done); end
    checks++;
    if (o_word_count !== 7'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", o_word_count); end
    checks++;
    if (o_instruction !== 32'h0 || o_addr_err !== 1'b0) begin
      errors++; $display("FAIL rst_outs: got %h/%b want 0/0", o_instruction, o_addr_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", o_load_ready); end
  endtask

  task automatic test_load_halt();
    send_word(32'h20010005);
    checks++;
    if (o_word_count !== 7'd1 || o_load_done !== 1'b0) begin
      errors++; $display("FAIL halt_word1: got cnt=%0d done=%b want 1/0", o_word_count, o_load_done);
    end
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    checks++;
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL halt_early: got done=%b want 0", o_load_done); end
    send_byte(8'hFF);
    checks++;
    if (o_word_count !== 7'd2 || o_load_done !== 1'b1 || o_load_ready !== 1'b0) begin
      errors++; $display("FAIL halt_run: got cnt=%0d done=%b rdy=%b want 2/1/0",
                         o_word_count, o_load_done, o_load_ready);
    end
  endtask

  task automatic test_fetch();
    fetch_check("fetch_pc0",   32'd0,   32'h20010005, 1'b0);
    fetch_check("fetch_pc4",   32'd4,   32'hFFFFFFFF, 1'b0);
    fetch_check("fetch_mis",   32'd2,   32'h0,        1'b1);
    fetch_check("fetch_pc8",   32'd8,   32'h0,        1'b1);
    fetch_check("fetch_pc256", 32'd256, 32'h0,        1'b1);
    fetch_check("fetch_pc0b",  32'd0,   32'h20010005, 1'b0);
  endtask

  task automatic test_stall();
    fetch_check("stall_pre", 32'd0, 32'h20010005, 1'b0);
    i_pc      = 32'd4;
    i_read_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_instruction !== 32'h20010005 || o_addr_err !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got %h/%b want 20010005/0", i, o_instruction, o_addr_err);
      end
    end
    fetch_check("stall_resume", 32'd4, 32'hFFFFFFFF, 1'b0);
    // Error flag must also hold across a stall.
    fetch_check("stall_err", 32'd3, 32'h0, 1'b1);
    i_pc = 32'd0;
    tick();
    checks++;
    if (o_addr_err !== 1'b1) begin errors++; $display("FAIL stall_err_hold: got %b want 1", o_addr_err); end
  endtask

  task automatic test_clear_mid_word();
    do_clear();
    checks++;
    if (o_word_count !== 7'd0 || o_load_ready !== 1'b1 || o_load_done !== 1'b0) begin
      errors++; $display("FAIL clr_state: got cnt=%0d rdy=%b done=%b want 0/1/0",
                         o_word_count, o_load_ready, o_load_done);
    end
    checks++;
    if (o_instruction !== 32'h0 || o_addr_err !== 1'b0) begin
      errors++; $display("FAIL clr_outs: got %h/%b want 0/0", o_instruction, o_addr_err);
    end
    // Fetch attempts while loading are ignored.
    i_pc = 32'd0; i_read_en = 1'b1;
    tick();
    i_read_en = 1'b0;
    checks++;
    if (o_instruction !== 32'h0 || o_addr_err !== 1'b0) begin
      errors++; $display("FAIL load_fetch: got %h/%b want 0/0", o_instruction, o_addr_err);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    i_load_clear = 1'b1;
    send_byte(8'h33);
    i_load_clear = 1'b0;
    checks++;
    if (o_word_count !== 7'd0) begin errors++; $display("FAIL clr_mid_count: got %0d want 0", o_word_count); end
    send_word(32'hAABBCCDD);
    checks++;
    if (o_word_count !== 7'd1) begin errors++; $display("FAIL clr_word0_count: got %0d want 1", o_word_count); end
    send_word(32'hFFFFFFFF);
    fetch_check("clr_word0", 32'd0, 32'hAABBCCDD, 1'b0);
  endtask

  task automatic test_full();
    do_clear();
    for (int n = 0; n < 63; n++) send_word(n);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (o_word_count !== 7'd63 || o_load_ready !== 1'b1) begin
      errors++; $display("FAIL full_pre: got cnt=%0d rdy=%b want 63/1", o_word_count, o_load_ready);
    end
    send_byte(8'h3F);
    checks++;
    if (o_word_count !== 7'd64 || o_load_ready !== 1'b0 || o_load_done !== 1'b1) begin
      errors++; $display("FAIL full_run: got cnt=%0d rdy=%b done=%b want 64/0/1",
                         o_word_count, o_load_ready, o_load_done);
    end
    send_word(32'h12345678);
    checks++;
    if (o_word_count !== 7'd64) begin errors++; $display("FAIL full_extra: got %0d want 64", o_word_count); end
    fetch_check("full_pc252", 32'd252, 32'd63, 1'b0);
    fetch_check("full_pc0",   32'd0,   32'd0,  1'b0);
    fetch_check("full_pc132", 32'd132, 32'd33, 1'b0);
    fetch_check("full_pc256", 32'd256, 32'd0,  1'b1);
  endtask

  task automatic test_reset_midload();
    do_clear();
    send_word(32'hCAFEF00D);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    #1;
    checks++;
    if (o_load_ready !== 1'b0) begin errors++; $display("FAIL rstml_ready: got %b want 0", o_load_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (o_load_ready !== 1'b1 || o_word_count !== 7'd0) begin
      errors++; $display("FAIL rstml_after: got rdy=%b cnt=%0d want 1/0", o_load_ready, o_word_count);
    end
    checks++;
    if (o_instruction !== 32'h0 || o_addr_err !== 1'b0 || o_load_done !== 1'b0) begin
      errors++; $display("FAIL rstml_outs: got %h/%b/%b want 0/0/0", o_instruction, o_addr_err, o_load_done);
    end
    send_word(32'h12345678);
    send_word(32'hFFFFFFFF);
    checks++;
    if (o_word_count !== 7'd2 || o_load_done !== 1'b1) begin
      errors++; $display("FAIL rstml_reload: got cnt=%0d done=%b want 2/1", o_word_count, o_load_done);
    end
    fetch_check("rstml_pc0", 32'd0, 32'h12345678, 1'b0);
    // Word 2 still holds old data from the full load but is not loaded now.
    fetch_check("rstml_pc8", 32'd8, 32'h0, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    i_load_valid = 1'b0;
    i_load_byte  = 8'h00;
    i_load_clear = 1'b0;
    i_pc         = 32'd0;
    i_read_en    = 1'b0;
    test_reset();
    test_load_halt();
    test_fetch();
    test_stall();
    test_clear_mid_word();
    test_full();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
Parametrised successor to the plain read-only instruction memory. Holds the program for the MIPS datapath's IF stage, and is filled at run time from a byte stream (debug unit / UART side) that is packed into words. After loading it serves registered, byte-addressed instruction fetches with stall support, alignment/range checking and NOP fill for unloaded words.

Parameters:
DATA_W, 32, instruction width in bits; must be a multiple of 8
DEPTH, 64, number of instruction words
ADDR_W, 6, word index width, equal to clog2(DEPTH)
PC_W, 32, width of the byte-address input
HALT_WORD, 32'hFFFFFFFF, word that terminates loading

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
i_load_valid  in  1  load byte valid
i_load_byte  in  8  load byte; first byte of a word lands in MSBs (big-endian)
o_load_ready  out  1  high while the block accepts load bytes
i_load_clear  in  1  restart loading from word 0
i_pc  in  PC_W  fetch byte address
i_read_en  in  1  fetch enable; 0 = stall, output held
o_instruction  out  DATA_W  fetched word, 1-cycle latency
o_addr_err  out  1  fetch was misaligned or out of the loaded range; aligned with o_instruction
o_load_done  out  1  level, high in RUN state
o_word_count  out  ADDR_W+1  number of complete words written

Behaviour:
- Synchronous reset:
  - state goes to LOAD; byte counter, write pointer and o_word_count are 0.
  - o_instruction, o_addr_err and o_load_done are 0. o_load_ready is 0 while rst is high.
  - Memory array contents are not cleared.
- States:
  - LOAD (o_load_ready=1): accepts bytes.
  - RUN (o_load_ready=0, o_load_done=1): serves fetches.
- Byte packing in LOAD:
  - A byte is accepted on any edge with i_load_valid=1.
  - The byte goes into the assembly register at bits [DATA_W-1-8k -: 8], where k is the byte counter (0..DATA_W/8-1).
  - On the last byte of a word: the full word is written to mem[wr_ptr], wr_ptr increments, o_word_count increments and the byte counter returns to 0.
- LOAD -> RUN transitions:
  - The completed word equals HALT_WORD: it is stored and counted, then the state moves to RUN on the same edge.
  - Or the write completes word DEPTH-1 (memory full): state moves to RUN, o_word_count=DEPTH.
- Bytes offered in RUN are ignored. o_load_ready=0 there, so there is no back-pressure hazard.
- i_load_clear (any state) has priority over i_load_valid on the same edge:
  - state goes to LOAD; wr_ptr, byte counter and o_word_count go to 0.
  - Any partial word and any same-cycle byte are discarded.
  - o_instruction and o_addr_err are cleared to 0.
- Fetch, RUN only:
  - On an edge with i_read_en=1, compute idx = i_pc[ADDR_W+1:2].
  - error = (i_pc[1:0]!=0) or (i_pc >= DEPTH*4) or (idx >= o_word_count).
  - If no error: o_instruction <= mem[idx], o_addr_err <= 0.
  - If error: o_instruction <= 0 (NOP), o_addr_err <= 1.
- Stall: with i_read_en=0, o_instruction and o_addr_err hold their previous values.
- Fetches in LOAD state: outputs stay 0; i_read_en is ignored.
- Memory is single write port, single read port, no read-during-write case: writes happen only in LOAD and reads only in RUN.
- Reset mid-load: the partial word is lost and o_word_count=0. Earlier words remain in the array but read as errors until they are reloaded.

Test Plan:
- Reset, then bytes 0x20,0x01,0x00,0x05 followed by 0xFF x4 -> o_word_count=2, o_load_done=1 on the edge of the 8th byte. Then i_pc=0, i_read_en=1 -> next cycle o_instruction=0x20010005, o_addr_err=0; i_pc=4 -> 0xFFFFFFFF.
- After the load above: i_pc=2 -> o_instruction=0, o_addr_err=1. i_pc=8 (beyond word_count) -> 0 with o_addr_err=1. i_pc=256 (>=DEPTH*4) -> error.
- Stall: fetch i_pc=0, then drop i_read_en and change i_pc=4 for 3 cycles -> o_instruction stays 0x20010005; raise i_read_en -> 0xFFFFFFFF one cycle later.
- Full memory: stream 64 non-halt words (word n = n) -> RUN after the 256th byte, o_word_count=64, o_load_ready=0. Extra bytes are ignored and i_pc=252 returns 63.
- Clear mid-word: send 2 bytes, assert i_load_clear together with a valid byte -> o_word_count=0, byte dropped. The next 4 bytes 0xAA,0xBB,0xCC,0xDD form word 0 = 0xAABBCCDD.
- Reset asserted after 6 bytes while in LOAD -> o_load_ready=0 during rst, then 1. o_word_count=0 and outputs are 0; reload proceeds from word 0.
